// File: rtl/preimage_scanner.sv
// rtl/preimage_scanner.sv - streams every 4-bit input code whose truth-table entry equals a requested 2-bit output
module preimage_scanner #(
   parameter logic [31:0] TABLE = 32'hEEEE_76EC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_target,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_code,
   output logic       out_last,
   output logic       done,
   output logic [4:0] match_count
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

   state_t      state, state_n;
   logic [4:0]  idx, idx_n;
   logic [15:0] mask, mask_n;
   logic [15:0] hit_mask;
   logic [15:0] mask_above;
   logic [3:0]  code_n;
   logic        valid_n, last_n, done_n;
   logic [4:0]  count_n;

   // req_ready stays low while reset is asserted, even though the state is already IDLE
   assign req_ready = (state == S_IDLE) && rst_n;

   always_comb begin
      hit_mask = '0;
      for (int i = 0; i < 16; i++) begin
         hit_mask[i] = (TABLE[2*i +: 2] == req_target);
      end
   end

   // Matches strictly above the current index decide whether this one is the last
   assign mask_above = mask & (16'hFFFE << idx[3:0]);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      mask_n  = mask;
      code_n  = out_code;
      valid_n = out_valid;
      last_n  = out_last;
      done_n  = 1'b0;
      count_n = match_count;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               mask_n  = hit_mask;
               idx_n   = 5'd0;
               count_n = 5'd0;
               state_n = S_SCAN;
            end
         end
         S_SCAN: begin
            if (mask[idx[3:0]]) begin
               code_n  = idx[3:0];
               valid_n = 1'b1;
               last_n  = (mask_above == 16'h0000);
               state_n = S_EMIT;
            end else if (idx == 5'd15) begin
               state_n = S_DONE;
               done_n  = 1'b1;
            end else begin
               idx_n = idx + 5'd1;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               valid_n = 1'b0;
               count_n = match_count + 5'd1;
               if (out_last) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  idx_n   = idx + 5'd1;
                  state_n = S_SCAN;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= 5'd0;
         mask        <= 16'h0000;
         out_code    <= 4'd0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         done        <= 1'b0;
         match_count <= 5'd0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         mask        <= mask_n;
         out_code    <= code_n;
         out_valid   <= valid_n;
         out_last    <= last_n;
         done        <= done_n;
         match_count <= count_n;
      end
   end

endmodule

// File: tb/tb_preimage_scanner.sv
// tb/tb_preimage_scanner.sv - directed table-driven bench for preimage_scanner
module tb_preimage_scanner;

   logic       clk;
   logic       rst_n;
   logic       req_valid, req_ready, out_valid, out_ready, out_last, done;
   logic [1:0] req_target;
   logic [3:0] out_code;
   logic [4:0] match_count;

   logic       e_req_valid, e_req_ready, e_out_valid, e_out_ready, e_out_last, e_done;
   logic [1:0] e_req_target;
   logic [3:0] e_out_code;
   logic [4:0] e_match_count;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [1:0]  target;
      int          mode;
      logic        hold;
      logic [1:0]  hold_target;
      logic [15:0] exp_mask;
      int          exp_first;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];

   preimage_scanner u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_target  (req_target),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_code    (out_code),
      .out_last    (out_last),
      .done        (done),
      .match_count (match_count)
   );

   preimage_scanner #(.TABLE(32'h0000_0000)) u_empty (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (e_req_valid),
      .req_ready   (e_req_ready),
      .req_target  (e_req_target),
      .out_valid   (e_out_valid),
      .out_ready   (e_out_ready),
      .out_code    (e_out_code),
      .out_last    (e_out_last),
      .done        (e_done),
      .match_count (e_match_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int cyc, n, first, dcyc, mc, waitc, exp_n, prev_code;
      int last_err, stall_err, busy_err, order_err;
      logic [15:0] got;
      logic pv, pr;
      logic [3:0] pc;
      string tag;
      tag = $sformatf("v%0d", id);
      n = 0; first = -1; dcyc = -1; mc = -1; waitc = 0; prev_code = -1;
      last_err = 0; stall_err = 0; busy_err = 0; order_err = 0;
      got = '0; pv = 1'b0; pr = 1'b0; pc = '0;
      exp_n = $countones(v.exp_mask);
      while (!req_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_ready_wait"}, int'(req_ready), 1);
      req_valid  = 1'b1;
      req_target = v.target;
      out_ready  = (v.mode == 0);
      @(negedge clk);
      cyc = 1;
      if (v.hold) req_target = v.hold_target;
      else req_valid = 1'b0;
      while (cyc < 60) begin
         out_ready = (v.mode == 0) ? 1'b1 : ((cyc % 2) == 1);
         if (pv && !pr && (!out_valid || out_code != pc)) stall_err++;
         if (req_ready) busy_err++;
         if (out_valid && first < 0) first = cyc;
         if (out_valid && out_ready) begin
            n++;
            got[out_code] = 1'b1;
            if (int'(out_code) <= prev_code) order_err++;
            prev_code = int'(out_code);
            if (out_last != (n == exp_n)) last_err++;
         end
         pv = out_valid;
         pr = out_ready;
         pc = out_code;
         if (done) begin
            dcyc = cyc;
            mc   = int'(match_count);
            break;
         end
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      check({tag, "_count"}, n, exp_n);
      check({tag, "_codes"}, int'(got), int'(v.exp_mask));
      check({tag, "_first_valid_cycle"}, first, v.exp_first);
      if (v.exp_done >= 0) check({tag, "_done_cycle"}, dcyc, v.exp_done);
      else check({tag, "_done_seen"}, int'(dcyc > 0), 1);
      check({tag, "_match_count"}, mc, exp_n);
      check({tag, "_last_errors"}, last_err, 0);
      check({tag, "_stall_errors"}, stall_err, 0);
      check({tag, "_busy_ready_errors"}, busy_err, 0);
      check({tag, "_order_errors"}, order_err, 0);
      check({tag, "_ready_after_done"}, int'(req_ready), 1);
      check({tag, "_done_one_cycle"}, int'(done), 0);
   endtask

   initial begin
      int cyc, ev, dcyc, mc;
      vecs[0] = '{2'b00, 0, 1'b0, 2'b00, 16'h0001, 2, 3};
      vecs[1] = '{2'b01, 0, 1'b0, 2'b00, 16'h00A0, 7, 11};
      vecs[2] = '{2'b11, 1, 1'b0, 2'b00, 16'hAA4A, 3, -1};
      vecs[3] = '{2'b10, 0, 1'b1, 2'b11, 16'h5514, 4, 22};
      vecs[4] = '{2'b11, 0, 1'b0, 2'b00, 16'hAA4A, 3, 24};

      rst_n = 1'b0;
      req_valid = 1'b0; req_target = 2'b00; out_ready = 1'b0;
      e_req_valid = 1'b0; e_req_target = 2'b00; e_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_code", int'(out_code), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_done", int'(done), 0);
      check("rst_match_count", int'(match_count), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", int'(req_ready), 1);

      // empty preimage on an all-zero table
      e_req_valid  = 1'b1;
      e_req_target = 2'b11;
      @(negedge clk);
      e_req_valid = 1'b0;
      cyc = 1; ev = 0; dcyc = -1; mc = -1;
      while (cyc < 40) begin
         if (e_out_valid) ev++;
         if (e_done) begin
            dcyc = cyc;
            mc   = int'(e_match_count);
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("empty_out_valid_cycles", ev, 0);
      check("empty_done_cycle", dcyc, 17);
      check("empty_match_count", mc, 0);
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // reset while code 6 is stalled
      req_valid  = 1'b1;
      req_target = 2'b11;
      out_ready  = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (cyc < 40) begin
         out_ready = !(out_valid && out_code == 4'd6);
         if (out_valid && out_code == 4'd6) break;
         @(negedge clk);
         cyc++;
      end
      check("rst_test_reach_code6", int'(out_valid && out_code == 4'd6), 1);
      @(negedge clk);
      check("rst_test_stall_code", int'(out_code), 6);
      check("rst_test_stall_valid", int'(out_valid), 1);
      check("rst_test_pre_count", int'(match_count), 2);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_test_out_valid", int'(out_valid), 0);
      check("rst_test_match_count", int'(match_count), 0);
      check("rst_test_req_ready", int'(req_ready), 1);
      check("rst_test_done", int'(done), 0);
      @(negedge clk);
      check("rst_test_no_done_later", int'(done), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
